// File: rtl/vec_addsub_pipe.sv
// Elastic vector add/subtract pipeline: per-lane wrap/saturating A+/-B with overflow flags,
// STAGES bubble-collapsing register stages under a vld/rdy handshake.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

module vec_addsub_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_sub,
    input  logic                  i_sat,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_ovf
);
    localparam int W = DATA_WIDTH;

    logic [W:0] w_a_ext;
    logic [W:0] w_b_ext;
    logic [W:0] w_exact;

    assign w_a_ext = {i_a[W-1], i_a};
    assign w_b_ext = {i_b[W-1], i_b};
    assign w_exact = i_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    // One extra bit holds the exact result; overflow iff the top two bits disagree.
    assign o_ovf = w_exact[W] ^ w_exact[W-1];

    always_comb begin
        o_res = w_exact[W-1:0];
        if (i_sat && o_ovf)
            o_res = w_exact[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
endmodule

module vec_addsub_pipe #(
    parameter int VEC_LEN    = `MAX_EMBEDDING_DIM,
    parameter int DATA_WIDTH = `INTEGER_WIDTH,
    parameter int STAGES     = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_vld_in,
    output logic                                 o_rdy_out,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]   i_a_in,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]   i_b_in,
    input  logic                                 i_sub_in,
    input  logic                                 i_sat_in,
    output logic                                 o_vld_out,
    input  logic                                 i_rdy_in,
    output logic [VEC_LEN-1:0][DATA_WIDTH-1:0]   o_sum,
    output logic [VEC_LEN-1:0]                   o_ovf
);
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0]              w_lane_sum;
    logic [VEC_LEN-1:0]                              w_lane_ovf;

    logic [STAGES:1]                                 r_vld_pipe;
    logic [STAGES:1][VEC_LEN-1:0][DATA_WIDTH-1:0]    r_sum;
    logic [STAGES:1][VEC_LEN-1:0]                    r_ovf;

    logic [STAGES:1]                                 w_load;
    logic                                            w_unload;
    logic [STAGES:1]                                 w_src_vld;
    logic [STAGES:1][VEC_LEN-1:0][DATA_WIDTH-1:0]    w_src_sum;
    logic [STAGES:1][VEC_LEN-1:0]                    w_src_ovf;

    for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
        vec_addsub_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .i_a   (i_a_in[i]),
            .i_b   (i_b_in[i]),
            .i_sub (i_sub_in),
            .i_sat (i_sat_in),
            .o_res (w_lane_sum[i]),
            .o_ovf (w_lane_ovf[i])
        );
    end

    // Stage k's source is stage k-1; stage 1 takes the freshly computed lane results.
    for (genvar k = 1; k <= STAGES; k++) begin : g_src
        if (k == 1) begin : g_first
            assign w_src_vld[k] = i_vld_in;
            assign w_src_sum[k] = w_lane_sum;
            assign w_src_ovf[k] = w_lane_ovf;
        end else begin : g_rest
            assign w_src_vld[k] = r_vld_pipe[k-1];
            assign w_src_sum[k] = r_sum[k-1];
            assign w_src_ovf[k] = r_ovf[k-1];
        end
    end

    // Ready ripples back from the output: a stage loads if empty or if its successor takes it.
    always_comb begin
        w_load   = '0;
        w_unload = i_rdy_in;
        for (int k = STAGES; k >= 1; k--) begin
            w_load[k] = !r_vld_pipe[k] || w_unload;
            w_unload  = w_load[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_vld_pipe <= '0;
            r_sum      <= '0;
            r_ovf      <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (w_load[k]) begin
                    r_vld_pipe[k] <= w_src_vld[k];
                    if (w_src_vld[k]) begin
                        r_sum[k] <= w_src_sum[k];
                        r_ovf[k] <= w_src_ovf[k];
                    end
                end
            end
        end
    end

    assign o_rdy_out = w_load[1];
    assign o_vld_out = r_vld_pipe[STAGES];
    assign o_sum     = r_sum[STAGES];
    assign o_ovf     = r_ovf[STAGES];
endmodule

// File: tb/tb_vec_addsub_pipe.sv
// Scoreboard bench for vec_addsub_pipe (W=8, VEC_LEN=4, STAGES=2): directed cases,
// backpressure, streaming, random handshake and mid-flight reset against a plain-arithmetic model.
module tb_vec_addsub_pipe;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ST = 2;

    typedef struct {
        logic [N-1:0][W-1:0] sum;
        logic [N-1:0]        ovf;
    } exp_t;

    logic                clk = 0;
    logic                rst = 0;
    logic                vld_in = 0;
    logic                rdy_out;
    logic [N-1:0][W-1:0] a_in = '0;
    logic [N-1:0][W-1:0] b_in = '0;
    logic                sub_in = 0;
    logic                sat_in = 0;
    logic                vld_out;
    logic                rdy_in = 0;
    logic [N-1:0][W-1:0] sum;
    logic [N-1:0]        ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   out_cyc[$];

    vec_addsub_pipe #(.VEC_LEN(N), .DATA_WIDTH(W), .STAGES(ST)) dut (
        .i_clk(clk), .i_rst(rst), .i_vld_in(vld_in), .o_rdy_out(rdy_out),
        .i_a_in(a_in), .i_b_in(b_in), .i_sub_in(sub_in), .i_sat_in(sat_in),
        .o_vld_out(vld_out), .i_rdy_in(rdy_in), .o_sum(sum), .o_ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [N-1:0][W-1:0] a, logic [N-1:0][W-1:0] b, logic sb, logic st);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            int x, y, r;
            logic [31:0] rv;
            x = $signed(a[i]);
            y = $signed(b[i]);
            r = sb ? x - y : x + y;
            e.ovf[i] = (r > 127) || (r < -128);
            if (st && e.ovf[i]) r = (r > 0) ? 127 : -128;
            rv = r;
            e.sum[i] = rv[W-1:0];
        end
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard push: an input transfer happens at the coming edge.
    always @(negedge clk)
        if (rst && vld_in && rdy_out) exp_q.push_back(model(a_in, b_in, sub_in, sat_in));

    // Monitor: pop and compare on every output transfer; check stall stability.
    logic                prev_stall = 0;
    logic [N-1:0][W-1:0] prev_sum;
    logic [N-1:0]        prev_ovf;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", 64'(vld_out), 64'd1);
                check("stall_sum", 64'(sum), 64'(prev_sum));
                check("stall_ovf", 64'(ovf), 64'(prev_ovf));
            end
            if (vld_out && rdy_in) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_output actual sum=%0h required=none", sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_sum", 64'(sum), 64'(e.sum));
                    check("out_ovf", 64'(ovf), 64'(e.ovf));
                    out_cyc.push_back(cyc);
                end
            end
            prev_stall = vld_out && !rdy_in;
            prev_sum   = sum;
            prev_ovf   = ovf;
        end
    end

    task automatic set_in(logic [N-1:0][W-1:0] a, logic [N-1:0][W-1:0] b, logic sb, logic st);
        a_in = a; b_in = b; sub_in = sb; sat_in = st; vld_in = 1;
    endtask

    // Holds vld_in until accepted; leaves vld_in high so the caller can stream.
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!rdy_out && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout actual rdy_out=0 required=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_rand();
        logic [N-1:0][W-1:0] a, b;
        for (int i = 0; i < N; i++) begin
            a[i] = W'($urandom);
            b[i] = ($urandom_range(0, 3) == 0) ? 8'h80 : W'($urandom);
        end
        set_in(a, b, 1'($urandom), 1'($urandom));
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || vld_out) && n < 300) begin @(posedge clk); #1; n++; end
        if (n >= 300) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout actual pending=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        logic [N-1:0][W-1:0] va, vb, v1, v2, v3, zero_v;
        int start;
        zero_v = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check("rst_rdy_out", 64'(rdy_out), 64'd1);
        check("rst_vld_out", 64'(vld_out), 64'd0);
        check("rst_sum", 64'(sum), 64'(zero_v));
        check("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;

        // Basic add, wrap; latency exactly STAGES
        rdy_in = 1;
        va = {8'd100, 8'd3, 8'd2, 8'd1};
        vb = {8'd100, 8'd1, 8'd1, 8'd1};
        set_in(va, vb, 0, 0);
        wait_accept();
        vld_in = 0;
        @(negedge clk);
        check("lat_early_vld", 64'(vld_out), 64'd0);
        @(negedge clk);
        check("lat_vld", 64'(vld_out), 64'd1);
        va = {8'hC8, 8'd4, 8'd3, 8'd2};
        check("basic_sum", 64'(sum), 64'(va));
        check("basic_ovf", 64'(ovf), 64'b1000);
        drain();

        // Saturating subtract
        va = {8'h80, 8'd127, 8'd0, 8'h9C};
        vb = {8'd1, 8'hFF, 8'd1, 8'd100};
        set_in(va, vb, 1, 1);
        wait_accept();
        vld_in = 0;
        repeat (2) @(negedge clk);
        va = {8'h80, 8'h7F, 8'hFF, 8'h80};
        check("sat_sum", 64'(sum), 64'(va));
        check("sat_ovf", 64'(ovf), 64'b1101);
        drain();

        // Backpressure fill
        rdy_in = 0;
        v1 = {4{8'h11}}; v2 = {4{8'h22}}; v3 = {4{8'h33}};
        set_in(v1, v1, 0, 0); wait_accept();
        set_in(v2, v2, 1, 0); wait_accept();
        set_in(v3, v3, 0, 1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("bp_rdy_out_full", 64'(rdy_out), 64'd0);
            @(posedge clk); #1;
        end
        rdy_in = 1;
        @(negedge clk);
        check("bp_rdy_same_cycle", 64'(rdy_out), 64'd1);
        check("bp_first_out", 64'(sum), 64'({4{8'h22}}));
        @(posedge clk); #1;
        vld_in = 0;
        drain();

        // Streaming: 16 back-to-back, outputs on consecutive cycles
        start = out_cyc.size();
        for (int j = 0; j < 16; j++) send_rand();
        vld_in = 0;
        drain();
        begin
            int consec = 1;
            if (out_cyc.size() != start + 16) consec = 0;
            else for (int j = 1; j < 16; j++)
                if (out_cyc[start+j] != out_cyc[start+j-1] + 1) consec = 0;
            check("stream_consecutive", 64'(consec), 64'd1);
        end

        // Random handshake
        begin
            bit done = 0;
            fork
                begin
                    for (int j = 0; j < 80; j++) begin
                        send_rand();
                        if ($urandom_range(0, 2) == 0) begin
                            vld_in = 0;
                            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                        end
                    end
                    vld_in = 0;
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge clk); #1;
                        rdy_in = ($urandom_range(0, 2) != 0);
                    end
                end
            join
        end
        rdy_in = 1;
        drain();

        // Reset mid-operation
        rdy_in = 0;
        send_rand();
        send_rand();
        vld_in = 0;
        rst = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_vld_out", 64'(vld_out), 64'd0);
        check("midrst_sum", 64'(sum), 64'(zero_v));
        check("midrst_rdy_out", 64'(rdy_out), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1;
        rdy_in = 1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_vld", 64'(vld_out), 64'd0);
        end
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) send_rand();
        vld_in = 0;
        drain();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
